// File: rtl/wb_arbiter_2.sv
// Two-master Wishbone arbiter (RR or fixed priority); grant registered, 1-cycle CYC-to-grant, data/ack paths combinational.
// Slave stalls pass straight through; `define WB_ARB_TIMEOUT_EN adds a watchdog that errors and aborts a stalled cycle.
module wb_arbiter_2 #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int SELECT_WIDTH    = DATA_WIDTH / 8,
    parameter int ARB_ROUND_ROBIN = 1,
    parameter int TIMEOUT         = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,
    output logic                    wbm0_rty_o,
    input  logic                    wbm0_cyc_i,
    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,
    output logic                    wbm1_rty_o,
    input  logic                    wbm1_cyc_i,
    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic                    wbs_cyc_o,
    output logic [1:0]              gnt_o
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_arbiter_2: TIMEOUT must be in 1..65535");
    end

    localparam bit RR = (ARB_ROUND_ROBIN != 0);

    // One-hot state encoding doubles as the registered grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q;
    logic   last_q;     // 1 = master 1 held the most recent grant
    logic   gcyc;
    logic   gstb;
    logic   abort;
    logic   to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wbm0_cyc_i && (!wbm1_cyc_i || !RR || last_q)) begin
                        state_q <= GNT0;
                        last_q  <= 1'b0;
                    end else if (wbm1_cyc_i) begin
                        state_q <= GNT1;
                        last_q  <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!wbm0_cyc_i) begin
                        if (wbm1_cyc_i) begin
                            state_q <= GNT1;
                            last_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                GNT1: begin
                    if (!wbm1_cyc_i) begin
                        if (wbm0_cyc_i) begin
                            state_q <= GNT0;
                            last_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o = state_q;

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        gcyc      = 1'b0;
        gstb      = 1'b0;
        case (state_q)
            GNT0: begin
                wbs_adr_o = wbm0_adr_i;
                wbs_dat_o = wbm0_dat_i;
                wbs_we_o  = wbm0_we_i;
                wbs_sel_o = wbm0_sel_i;
                gcyc      = wbm0_cyc_i;
                gstb      = wbm0_stb_i;
            end
            GNT1: begin
                wbs_adr_o = wbm1_adr_i;
                wbs_dat_o = wbm1_dat_i;
                wbs_we_o  = wbm1_we_i;
                wbs_sel_o = wbm1_sel_i;
                gcyc      = wbm1_cyc_i;
                gstb      = wbm1_stb_i;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        abort_q;
    logic        stall;

    // Granted cyc low is the only way out of a grant, so it also covers grant changes.
    assign stall  = gcyc && gstb && !abort_q && !(wbs_ack_i || wbs_err_i || wbs_rty_i);
    assign to_hit = stall && (cnt_q == 16'(TIMEOUT - 1));
    assign abort  = abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            if (!gcyc || wbs_ack_i || wbs_err_i || wbs_rty_i) begin
                cnt_q <= '0;
            end else if (stall) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (!gcyc) begin
                abort_q <= 1'b0;
            end else if (to_hit) begin
                abort_q <= 1'b1;
            end
        end
    end
`else
    assign to_hit = 1'b0;
    assign abort  = 1'b0;
`endif

    assign wbs_cyc_o = gcyc && !abort;
    assign wbs_stb_o = gstb && !abort;

    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;

    assign wbm0_ack_o = (state_q == GNT0) && wbm0_cyc_i && wbs_ack_i;
    assign wbm0_err_o = (state_q == GNT0) && wbm0_cyc_i && (wbs_err_i || to_hit);
    assign wbm0_rty_o = (state_q == GNT0) && wbm0_cyc_i && wbs_rty_i;
    assign wbm1_ack_o = (state_q == GNT1) && wbm1_cyc_i && wbs_ack_i;
    assign wbm1_err_o = (state_q == GNT1) && wbm1_cyc_i && (wbs_err_i || to_hit);
    assign wbm1_rty_o = (state_q == GNT1) && wbm1_cyc_i && wbs_rty_i;

endmodule

// File: tb/tb_wb_arbiter_2.sv
// Bench for wb_arbiter_2: RR and fixed-priority instances share master stimulus; a slave model answers the RR instance.
// Read data expectations are queued per master at issue time and retired when that master sees ack.
module tb_wb_arbiter_2;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cyc = '0;
    logic [1:0]  stb = '0;
    logic [1:0]  we  = '0;
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];
    logic [31:0] s_dat = '0;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic        s_rty = 1'b0;

    logic [31:0] wbm0_dat_o, wbm1_dat_o, wbs_adr_o, wbs_dat_o;
    logic        wbm0_ack_o, wbm0_err_o, wbm0_rty_o, wbm1_ack_o, wbm1_err_o, wbm1_rty_o;
    logic        wbs_we_o, wbs_stb_o, wbs_cyc_o;
    logic [3:0]  wbs_sel_o;
    logic [1:0]  gnt_o;

    logic [31:0] fp_m0_dat, fp_m1_dat, fp_adr, fp_dat;
    logic        fp_m0_ack, fp_m0_err, fp_m0_rty, fp_m1_ack, fp_m1_err, fp_m1_rty;
    logic        fp_we, fp_stb, fp_cyc;
    logic [3:0]  fp_sel;
    logic [1:0]  fp_gnt;

    always #5 clk = ~clk;

    wb_arbiter_2 #(.ARB_ROUND_ROBIN(1), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .wbm0_adr_i(adr[0]), .wbm0_dat_i(dat[0]), .wbm0_dat_o(wbm0_dat_o), .wbm0_we_i(we[0]),
        .wbm0_sel_i(sel[0]), .wbm0_stb_i(stb[0]), .wbm0_ack_o(wbm0_ack_o), .wbm0_err_o(wbm0_err_o),
        .wbm0_rty_o(wbm0_rty_o), .wbm0_cyc_i(cyc[0]),
        .wbm1_adr_i(adr[1]), .wbm1_dat_i(dat[1]), .wbm1_dat_o(wbm1_dat_o), .wbm1_we_i(we[1]),
        .wbm1_sel_i(sel[1]), .wbm1_stb_i(stb[1]), .wbm1_ack_o(wbm1_ack_o), .wbm1_err_o(wbm1_err_o),
        .wbm1_rty_o(wbm1_rty_o), .wbm1_cyc_i(cyc[1]),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_i(s_dat), .wbs_dat_o(wbs_dat_o), .wbs_we_o(wbs_we_o),
        .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
        .wbs_rty_i(s_rty), .wbs_cyc_o(wbs_cyc_o), .gnt_o(gnt_o)
    );

    wb_arbiter_2 #(.ARB_ROUND_ROBIN(0), .TIMEOUT(TO)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .wbm0_adr_i(adr[0]), .wbm0_dat_i(dat[0]), .wbm0_dat_o(fp_m0_dat), .wbm0_we_i(we[0]),
        .wbm0_sel_i(sel[0]), .wbm0_stb_i(stb[0]), .wbm0_ack_o(fp_m0_ack), .wbm0_err_o(fp_m0_err),
        .wbm0_rty_o(fp_m0_rty), .wbm0_cyc_i(cyc[0]),
        .wbm1_adr_i(adr[1]), .wbm1_dat_i(dat[1]), .wbm1_dat_o(fp_m1_dat), .wbm1_we_i(we[1]),
        .wbm1_sel_i(sel[1]), .wbm1_stb_i(stb[1]), .wbm1_ack_o(fp_m1_ack), .wbm1_err_o(fp_m1_err),
        .wbm1_rty_o(fp_m1_rty), .wbm1_cyc_i(cyc[1]),
        .wbs_adr_o(fp_adr), .wbs_dat_i(s_dat), .wbs_dat_o(fp_dat), .wbs_we_o(fp_we),
        .wbs_sel_o(fp_sel), .wbs_stb_o(fp_stb), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
        .wbs_rty_i(s_rty), .wbs_cyc_o(fp_cyc), .gnt_o(fp_gnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference grant model, clocked alongside the DUTs.
    function automatic logic [1:0] nxt(input logic [1:0] g, input logic last,
                                       input logic c0, input logic c1, input bit rr);
        case (g)
            2'b01:   return c0 ? 2'b01 : (c1 ? 2'b10 : 2'b00);
            2'b10:   return c1 ? 2'b10 : (c0 ? 2'b01 : 2'b00);
            default: begin
                if (c0 && c1) return (rr && !last) ? 2'b10 : 2'b01;
                if (c0)       return 2'b01;
                if (c1)       return 2'b10;
                return 2'b00;
            end
        endcase
    endfunction

    logic [1:0] m_gnt = 2'b00, f_gnt = 2'b00, prev_gnt = 2'b00;
    logic       m_last = 1'b1, f_last = 1'b1;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [1:0]  seq [$];
    bit          no_ack = 1'b0;
    int          wcnt = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_gnt = 2'b00; m_last = 1'b1; f_gnt = 2'b00; f_last = 1'b1;
        end else begin
            m_gnt = nxt(m_gnt, m_last, cyc[0], cyc[1], 1'b1);
            if (m_gnt != 2'b00) m_last = m_gnt[1];
            f_gnt = nxt(f_gnt, f_last, cyc[0], cyc[1], 1'b0);
            if (f_gnt != 2'b00) f_last = f_gnt[1];
        end
    end

    // Slave: acks on the second cycle of a strobe, returning the inverted address.
    initial forever begin
        @(posedge clk);
        #2;
        if (s_ack) begin
            s_ack = 1'b0;
        end else if (wbs_cyc_o && wbs_stb_o && !no_ack) begin
            if (wcnt == 1) begin
                s_ack = 1'b1;
                s_dat = ~wbs_adr_o;
                wcnt  = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        check("gnt_rr", gnt_o, m_gnt);
        check("gnt_fp", fp_gnt, f_gnt);
        if (wbm0_ack_o || wbm1_ack_o) check("ack_route", {wbm1_ack_o, wbm0_ack_o}, m_gnt);
        if (wbm0_ack_o) begin
            if (q0.size() == 0) check("ack0_spurious", q0.size(), 1);
            else                check("rdat0", wbm0_dat_o, q0.pop_front());
        end
        if (wbm1_ack_o) begin
            if (q1.size() == 0) check("ack1_spurious", q1.size(), 1);
            else                check("rdat1", wbm1_dat_o, q1.pop_front());
        end
        if (gnt_o != prev_gnt && gnt_o != 2'b00) seq.push_back(gnt_o);
        prev_gnt = gnt_o;
    end

    task automatic wb_cycle(input int m, input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
        bit seen = 1'b0;
        rd = '0;
        cyc[m] = 1'b1; stb[m] = 1'b1; adr[m] = a; we[m] = w; dat[m] = d; sel[m] = s;
        if (m == 0) q0.push_back(~a); else q1.push_back(~a);
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = (m == 0) ? wbm0_ack_o : wbm1_ack_o;
            if (seen) rd = (m == 0) ? wbm0_dat_o : wbm1_dat_o;
        end
        check($sformatf("ack_wait_m%0d", m), seen, 1);
        @(posedge clk); #1;
        cyc[m] = 1'b0; stb[m] = 1'b0; adr[m] = '0; we[m] = 1'b0; dat[m] = '0; sel[m] = '0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "bench did not terminate");
    end

    initial begin
        logic [31:0] rd0, rd1;
        int err_at, err_cnt, cyc_bad;
        for (int i = 0; i < 2; i++) begin
            adr[i] = '0; dat[i] = '0; sel[i] = '0;
        end
        #2;
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_cyc_stb_we", {wbs_cyc_o, wbs_stb_o, wbs_we_o}, 3'b000);
        check("rst_resp", {wbm0_ack_o, wbm0_err_o, wbm0_rty_o, wbm1_ack_o, wbm1_err_o, wbm1_rty_o}, 6'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single master 0 read.
        fork
            wb_cycle(0, 32'h2152_4110, 1'b0, 32'h0, 4'hF, rd0);
            begin
                @(negedge clk); check("t1_gnt_before", gnt_o, 2'b00);
                @(negedge clk); check("t1_gnt_after", gnt_o, 2'b01);
                check("t1_wbs_cyc", wbs_cyc_o, 1'b1);
                check("t1_m1_ack", wbm1_ack_o, 1'b0);
            end
        join
        check("t1_rdata", rd0, 32'hDEADBEEF);

        // Simultaneous request after reset: master 0 first, direct handover.
        do_reset();
        fork
            wb_cycle(0, 32'h0000_0100, 1'b0, 32'h0, 4'hF, rd0);
            wb_cycle(1, 32'h0000_0200, 1'b0, 32'h0, 4'hF, rd1);
            begin
                @(negedge clk); @(negedge clk);
                check("t2_first", gnt_o, 2'b01);
                for (int n = 0; n < 60 && gnt_o == 2'b01; n++) @(negedge clk);
                check("t2_handover", gnt_o, 2'b10);
            end
        join

        // Back-to-back cycles from both masters alternate.
        seq.delete();
        fork
            for (int k = 0; k < 3; k++) wb_cycle(0, 32'h0000_1000 + 32'(k), 1'b0, 32'h0, 4'hF, rd0);
            for (int k = 0; k < 3; k++) wb_cycle(1, 32'h0000_2000 + 32'(k), 1'b0, 32'h0, 4'hF, rd1);
        join
        check("t3_seq_len", seq.size(), 6);
        for (int i = 0; i < 6 && i < seq.size(); i++)
            check($sformatf("t3_seq%0d", i), seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);

        // Tie after master 0 last won: RR picks master 1, fixed priority picks master 0.
        wb_cycle(0, 32'h0000_3000, 1'b0, 32'h0, 4'hF, rd0);
        fork
            wb_cycle(0, 32'h0000_3100, 1'b0, 32'h0, 4'hF, rd0);
            wb_cycle(1, 32'h0000_3200, 1'b0, 32'h0, 4'hF, rd1);
            begin
                @(negedge clk); @(negedge clk);
                check("t4_rr_tie", gnt_o, 2'b10);
                check("t4_fp_tie", fp_gnt, 2'b01);
            end
        join

        // Master 1 write with master 0 idle.
        fork
            wb_cycle(1, 32'h0000_1000, 1'b1, 32'h5A5A_5A5A, 4'hF, rd1);
            begin
                @(negedge clk); @(negedge clk);
                check("t5_adr", wbs_adr_o, 32'h0000_1000);
                check("t5_dat", wbs_dat_o, 32'h5A5A_5A5A);
                check("t5_sel", wbs_sel_o, 4'hF);
                check("t5_we", wbs_we_o, 1'b1);
                check("t5_m0_resp", {wbm0_ack_o, wbm0_err_o, wbm0_rty_o}, 3'b000);
            end
        join

        // Asynchronous reset during a master 1 grant.
        no_ack = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h0000_4000;
        @(negedge clk); @(negedge clk);
        check("t6_gnt1", gnt_o, 2'b10);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("t6_async_gnt", gnt_o, 2'b00);
        check("t6_async_cyc", {wbs_cyc_o, wbs_stb_o}, 2'b00);
        check("t6_async_ack", wbm1_ack_o, 1'b0);
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0; adr[1] = '0;
        rst_n = 1'b1; no_ack = 1'b0;
        fork
            wb_cycle(0, 32'h0000_5000, 1'b0, 32'h0, 4'hF, rd0);
            begin
                @(negedge clk); @(negedge clk);
                check("t6_regrant", gnt_o, 2'b01);
            end
        join

        // Slave that never responds.
        no_ack = 1'b1;
        err_at = 0; err_cnt = 0; cyc_bad = 0;
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h0000_6000;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (wbm0_err_o) begin
                err_cnt++;
                if (err_at == 0) err_at = n;
            end else if (err_at != 0 && wbs_cyc_o) begin
                cyc_bad++;
            end
        end
`ifdef WB_ARB_TIMEOUT_EN
        check("t7_err_stall_idx", err_at - 1, 8);
        check("t7_err_width", err_cnt, 1);
        check("t7_cyc_forced_low", cyc_bad, 0);
        check("t7_held_gnt", gnt_o, 2'b01);
`else
        check("t7_no_err", err_cnt, 0);
        check("t7_still_cyc", wbs_cyc_o, 1'b1);
        check("t7_held_gnt", gnt_o, 2'b01);
`endif
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb[0] = 1'b0; adr[0] = '0;
        @(negedge clk); @(negedge clk);
        check("t7_release", gnt_o, 2'b00);
        @(posedge clk); #1;
        no_ack = 1'b0;
        wb_cycle(0, 32'h0000_7000, 1'b0, 32'h0, 4'hF, rd0);
        check("t7_rearb_rdata", rd0, 32'hFFFF_8FFF);

        repeat (3) @(negedge clk);
        check("q_drained", q0.size() + q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
